io_arbiter: RTL and testbench
=============================

// Module: io_arbiter
// PURPOSE
// - Shares the single IO-space request port between two masters: M0 = CPU data port, M1 = debug/DMA master.
// - Sits between the masters and io_space; issues at most one IO transaction per cycle and routes each response back to its issuer.
// - Supports bus locking for atomic read-modify-write sequences, with a bounded hold time.
// PARAMETERS
// - RAM_DEPTH  14  IO address width; must match io_space.
// - HOLD_MAX   16  maximum cycles a master may keep a lock before forced release; legal range 2..255.
// PORTS
// - CLK            in   1          clock; all state updates on rising edge
// - RESET          in   1          reset; asynchronous, active-low
// - Mx_REQ         in   1          x=0,1: transaction request; held until Mx_GNT
// - Mx_WE/Mx_RE    in   1 each     write / read strobe
// - Mx_LOCK        in   1          keep ownership after this transaction
// - Mx_ADDR        in   RAM_DEPTH  IO address
// - Mx_WD          in   32         write data
// - M0_DBE         in   1          CPU data-bus exception; forwarded only when M0 is granted
// - Mx_GNT         out  1          transaction accepted this cycle (combinational)
// - Mx_RVALID      out  1          response cycle for the issuing master
// - Mx_RD          out  32         read data; valid when Mx_RVALID=1
// - IO_REQ/IO_WE/IO_RE/IO_DBE  out  1    to io_space
// - IO_ADDR        out  RAM_DEPTH  to io_space
// - IO_WD          out  32         to io_space
// - IO_RD          in   32         from io_space; valid one cycle after issue
// BEHAVIOUR
// - Reset: state IDLE, rr_ptr=M0, lock_cnt=0, owner_q=none, all registered outputs 0. Mx_GNT and IO_* are 0 while RESET is low.
// - Issue (cycle N): the winner gets Mx_GNT=1; IO_REQ=1; IO_WE, IO_RE, IO_ADDR and IO_WD are muxed from the winner.
//   IO_DBE = M0_DBE & M0_GNT. With no grant: IO_REQ=0, IO_WE=0, IO_RE=0, IO_DBE=0.
// - Response (cycle N+1): owner_q routes the response. The owner's Mx_RVALID=1 and Mx_RD=IO_RD. The other master's RD is 0.
//   Writes also get RVALID as an acknowledge.
// - Back-to-back issue is allowed every cycle. Response latency is fixed at 1 cycle and there is no stall path.
// - FSM states:
//   - IDLE: arbitrate (see CONFIGURATION).
//     If the winner's LOCK=1, go to LOCK0 or LOCK1 and clear lock_cnt.
//   - LOCKx: only Mx can be granted; the other master's request waits.
//     lock_cnt increments every cycle, including idle cycles.
//     Go to IDLE when Mx is granted with LOCK=0, or when lock_cnt==HOLD_MAX-1 (forced release).
//     On forced release, rr_ptr points to the other master, in both configurations.
// - Simultaneous requests in IDLE: exactly one grant per cycle; the loser's request stays pending, with no drop and no duplicate.
// - Forced release in the same cycle as an Mx grant with LOCK=1: the grant completes and the state still goes to IDLE.
// - Reset mid-transaction: the outstanding response is discarded; no RVALID is issued after reset releases.
// - REQ without WE or RE: granted and forwarded unchanged; it is a no-op in io_space.
// CONFIGURATION
// - Macro IO_ARBITER_RR_EN.
//   - Defined: round-robin. When both request in IDLE, the rr_ptr master wins. After any IDLE grant, rr_ptr moves to the non-winner.
//   - Undefined: fixed priority in IDLE, M0 wins. rr_ptr is used only after a forced release, for one arbitration, then reverts to M0 priority.
// - LOCK and forced-release behaviour are identical in both builds.
// STRUCTURE
// - Package io_arb_pkg:
//   - typedef enum {IDLE, LOCK0, LOCK1} io_arb_state_t;
//   - typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} io_owner_t;
//   - localparam LOCK_CNT_W = 8.
// - Sub-module io_arb_pick: 2-way combinational picker; inputs req[1:0], prio; output one-hot gnt[1:0].
// - Registers: state, rr_ptr, lock_cnt, owner_q. Implemented with the team's ffd flops, async-reset variant.
// TESTING
// - Reset: hold RESET=0 with both REQ=1 -> all GNT=0, IO_REQ=0, RVALID=0. Release -> M0 granted in the first cycle.
// - M0 alone reads 0x0010 -> M0_GNT=1 and IO_ADDR=0x0010 in cycle N; IO_RD=0xA5A5_0001 gives M0_RVALID=1 and M0_RD=0xA5A5_0001 in N+1; M1_RVALID=0.
// - Both request every cycle for 8 cycles:
//   - RR build -> grants alternate M0,M1,M0,... with 4 grants each.
//   - Fixed build -> 8 grants to M0, 0 to M1.
// - M1 LOCK write 0x0030, then M1 read, with M0 requesting throughout -> M0 gets no grant until M1 is granted with LOCK=0; M0 is granted the next cycle.
// - M0 holds LOCK=1 for 20 cycles, HOLD_MAX=16, M1 requesting -> forced release after cycle 16; M1 granted in cycle 17.
// - M0_DBE=1 with M0 granted -> IO_DBE=1. M0_DBE=1 with M1 granted -> IO_DBE=0.
// - RESET asserted in cycle N+1 of an M1 read -> M1_RVALID stays 0 throughout and after release.

Source files
------------

// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared types and constants for the IO-space arbiter.
//   io_arb_state_t : arbiter FSM states (IDLE, LOCK0, LOCK1)
//   io_owner_t     : which master issued the transaction now in its response cycle
//   LOCK_CNT_W     : width of the lock hold counter (supports HOLD_MAX up to 255)
//   owner_of()     : maps a one-hot grant vector to the response owner
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } io_arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } io_owner_t;

  localparam int LOCK_CNT_W = 8;

  // Grant vector is one-hot or zero; anything else is treated as no owner.
  function automatic io_owner_t owner_of(input logic [1:0] gnt);
    io_owner_t own;
    case (gnt)
      2'b01:   own = OWN_M0;
      2'b10:   own = OWN_M1;
      default: own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/io_arb_pick.sv
// io_arb_pick: 2-way combinational priority picker.
//   req[1:0] in  : request vector, bit 0 = M0, bit 1 = M1
//   prio     in  : master that wins when both request (0 = M0, 1 = M1)
//   gnt[1:0] out : one-hot grant, or zero when nobody requests
module io_arb_pick (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // Preferred master first, other master only when the preferred one is quiet.
  always_comb begin
    gnt = 2'b00;
    if (prio == 1'b0) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
      else             gnt = 2'b00;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
      else             gnt = 2'b00;
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// io_arbiter: shares the single IO-space request port between M0 (CPU data
// port) and M1 (debug/DMA). At most one transaction is issued per cycle; the
// response one cycle later is routed back to the issuer via owner_q.
// Bus locking keeps ownership for read-modify-write sequences, with a forced
// release after HOLD_MAX cycles.
//
// Build option: define IO_ARBITER_RR_EN for round-robin arbitration in IDLE;
// without it M0 has fixed priority (rr_ptr only matters for the single
// arbitration following a forced lock release).
//
// Ports:
//   CLK, RESET (async, active-low)
//   Mx_REQ/WE/RE/LOCK/ADDR/WD  in  : master x transaction request
//   M0_DBE                     in  : CPU data-bus exception, forwarded on M0 grants
//   Mx_GNT                     out : combinational accept
//   Mx_RVALID/Mx_RD            out : response cycle and read data for the issuer
//   IO_REQ/WE/RE/DBE/ADDR/WD   out : issued transaction to io_space
//   IO_RD                      in  : io_space read data, one cycle after issue
module io_arbiter
  import io_arb_pkg::*;
#(
  parameter int RAM_DEPTH = 14,
  parameter int HOLD_MAX  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 M0_REQ,
  input  logic                 M0_WE,
  input  logic                 M0_RE,
  input  logic                 M0_LOCK,
  input  logic [RAM_DEPTH-1:0] M0_ADDR,
  input  logic [31:0]          M0_WD,
  input  logic                 M0_DBE,
  output logic                 M0_GNT,
  output logic                 M0_RVALID,
  output logic [31:0]          M0_RD,
  input  logic                 M1_REQ,
  input  logic                 M1_WE,
  input  logic                 M1_RE,
  input  logic                 M1_LOCK,
  input  logic [RAM_DEPTH-1:0] M1_ADDR,
  input  logic [31:0]          M1_WD,
  output logic                 M1_GNT,
  output logic                 M1_RVALID,
  output logic [31:0]          M1_RD,
  output logic                 IO_REQ,
  output logic                 IO_WE,
  output logic                 IO_RE,
  output logic                 IO_DBE,
  output logic [RAM_DEPTH-1:0] IO_ADDR,
  output logic [31:0]          IO_WD,
  input  logic [31:0]          IO_RD
);

  localparam logic [LOCK_CNT_W-1:0] CNT_LAST = LOCK_CNT_W'(HOLD_MAX - 1);

  io_arb_state_t         state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;   // 0 = M0 preferred, 1 = M1 preferred
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  io_owner_t             owner_q, owner_d;

  logic [1:0] req_elig;
  logic [1:0] pick_gnt;
  logic [1:0] gnt;
  logic       win_lock;
  logic       forced_rel;

  // Masters eligible this cycle: both in IDLE, only the lock holder otherwise.
  always_comb begin
    req_elig = 2'b00;
    case (state_q)
      IDLE:    req_elig = {M1_REQ, M0_REQ};
      LOCK0:   req_elig = {1'b0, M0_REQ};
      LOCK1:   req_elig = {M1_REQ, 1'b0};
      default: req_elig = 2'b00;
    endcase
  end

  io_arb_pick u_pick (
    .req  (req_elig),
    .prio (rr_ptr_q),
    .gnt  (pick_gnt)
  );

  // Grants are suppressed while reset is asserted so nothing leaks to io_space.
  assign gnt        = RESET ? pick_gnt : 2'b00;
  assign M0_GNT     = gnt[0];
  assign M1_GNT     = gnt[1];
  assign win_lock   = gnt[1] ? M1_LOCK : M0_LOCK;
  assign forced_rel = (lock_cnt_q == CNT_LAST);

  // Forward the winner's transaction to io_space; all zero when nobody wins.
  always_comb begin
    IO_REQ  = 1'b0;
    IO_WE   = 1'b0;
    IO_RE   = 1'b0;
    IO_ADDR = '0;
    IO_WD   = 32'h0000_0000;
    if (gnt[1]) begin
      IO_REQ  = 1'b1;
      IO_WE   = M1_WE;
      IO_RE   = M1_RE;
      IO_ADDR = M1_ADDR;
      IO_WD   = M1_WD;
    end else if (gnt[0]) begin
      IO_REQ  = 1'b1;
      IO_WE   = M0_WE;
      IO_RE   = M0_RE;
      IO_ADDR = M0_ADDR;
      IO_WD   = M0_WD;
    end else begin
      IO_REQ  = 1'b0;
    end
  end

  assign IO_DBE = M0_DBE & gnt[0];

  // Response routing: one-cycle fixed latency, so owner_q names the issuer.
  assign M0_RVALID = (owner_q == OWN_M0);
  assign M1_RVALID = (owner_q == OWN_M1);
  assign M0_RD     = (owner_q == OWN_M0) ? IO_RD : 32'h0000_0000;
  assign M1_RD     = (owner_q == OWN_M1) ? IO_RD : 32'h0000_0000;

  // Next-state logic for FSM, rr pointer, lock counter and response owner.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    owner_d    = owner_of(gnt);
    case (state_q)
      IDLE: begin
        lock_cnt_d = '0;
        if (gnt != 2'b00) begin
`ifdef IO_ARBITER_RR_EN
          rr_ptr_d = gnt[0];      // point at the non-winner
`else
          rr_ptr_d = 1'b0;        // any post-release preference is used up
`endif
          if (win_lock) begin
            state_d = gnt[0] ? LOCK0 : LOCK1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCK0: begin
        lock_cnt_d = lock_cnt_q + 8'd1;
        // A grant in the forced-release cycle still completes normally.
        if (forced_rel) begin
          state_d    = IDLE;
          rr_ptr_d   = 1'b1;
          lock_cnt_d = '0;
        end else if (gnt[0] && !M0_LOCK) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else begin
          state_d    = LOCK0;
        end
      end
      LOCK1: begin
        lock_cnt_d = lock_cnt_q + 8'd1;
        if (forced_rel) begin
          state_d    = IDLE;
          rr_ptr_d   = 1'b0;
          lock_cnt_d = '0;
        end else if (gnt[1] && !M1_LOCK) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else begin
          state_d    = LOCK1;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset also discards any outstanding response.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      lock_cnt_q <= '0;
      owner_q    <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      owner_q    <= owner_d;
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed, table-driven bench for io_arbiter plus hand-written
// sequences for reset, arbitration fairness, lock forced release and reset
// during an outstanding response.
module tb_io_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        M0_REQ, M0_WE, M0_RE, M0_LOCK, M0_DBE;
  logic [13:0] M0_ADDR;
  logic [31:0] M0_WD;
  logic        M1_REQ, M1_WE, M1_RE, M1_LOCK;
  logic [13:0] M1_ADDR;
  logic [31:0] M1_WD;
  logic        M0_GNT, M0_RVALID, M1_GNT, M1_RVALID;
  logic [31:0] M0_RD, M1_RD;
  logic        IO_REQ, IO_WE, IO_RE, IO_DBE;
  logic [13:0] IO_ADDR;
  logic [31:0] IO_WD, IO_RD;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  io_arbiter #(.RAM_DEPTH(14), .HOLD_MAX(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_RE(M0_RE), .M0_LOCK(M0_LOCK),
    .M0_ADDR(M0_ADDR), .M0_WD(M0_WD), .M0_DBE(M0_DBE),
    .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID), .M0_RD(M0_RD),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_RE(M1_RE), .M1_LOCK(M1_LOCK),
    .M1_ADDR(M1_ADDR), .M1_WD(M1_WD),
    .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID), .M1_RD(M1_RD),
    .IO_REQ(IO_REQ), .IO_WE(IO_WE), .IO_RE(IO_RE), .IO_DBE(IO_DBE),
    .IO_ADDR(IO_ADDR), .IO_WD(IO_WD), .IO_RD(IO_RD)
  );

  // Bit 0 = M0, bit 1 = M1. e_io = {IO_REQ, IO_WE, IO_RE, IO_DBE}.
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  re;
    logic [1:0]  lock;
    logic        dbe;
    logic [13:0] a0;
    logic [13:0] a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [31:0] io_rd;
    logic [1:0]  e_gnt;
    logic [3:0]  e_io;
    logic [13:0] e_addr;
    logic [31:0] e_wd;
    logic [1:0]  e_rv;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    M0_REQ = 1'b0; M0_WE = 1'b0; M0_RE = 1'b0; M0_LOCK = 1'b0; M0_DBE = 1'b0;
    M0_ADDR = 14'h0; M0_WD = 32'h0;
    M1_REQ = 1'b0; M1_WE = 1'b0; M1_RE = 1'b0; M1_LOCK = 1'b0;
    M1_ADDR = 14'h0; M1_WD = 32'h0;
    IO_RD = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    M0_REQ = v.req[0]; M0_WE = v.we[0]; M0_RE = v.re[0]; M0_LOCK = v.lock[0];
    M0_ADDR = v.a0; M0_WD = v.wd0; M0_DBE = v.dbe;
    M1_REQ = v.req[1]; M1_WE = v.we[1]; M1_RE = v.re[1]; M1_LOCK = v.lock[1];
    M1_ADDR = v.a1; M1_WD = v.wd1;
    IO_RD = v.io_rd;
  endtask

  // Leaves the bench 1 time unit after a rising edge, DUT in IDLE with rr_ptr=M0.
  task automatic do_reset();
    idle_inputs();
    RESET = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  initial begin
    int c0, c1;
    logic [1:0] exp_g;

    tbl[0]  = '{2'b01,2'b00,2'b01,2'b00,1'b0,14'h0010,14'h0000,32'h0,32'h0,32'h0,              2'b01,4'b1010,14'h0010,32'h0,         2'b00,32'h0,32'h0};
    tbl[1]  = '{2'b00,2'b00,2'b00,2'b00,1'b0,14'h0000,14'h0000,32'h0,32'h0,32'hA5A5_0001,      2'b00,4'b0000,14'h0000,32'h0,         2'b01,32'hA5A5_0001,32'h0};
    tbl[2]  = '{2'b10,2'b10,2'b00,2'b00,1'b0,14'h0000,14'h0020,32'h0,32'h1234_5678,32'hDEAD_0000, 2'b10,4'b1100,14'h0020,32'h1234_5678, 2'b00,32'h0,32'h0};
    tbl[3]  = '{2'b01,2'b01,2'b00,2'b00,1'b1,14'h0040,14'h0000,32'h0BAD_0001,32'h0,32'h1111_1111, 2'b01,4'b1101,14'h0040,32'h0BAD_0001, 2'b10,32'h0,32'h1111_1111};
    tbl[4]  = '{2'b10,2'b00,2'b10,2'b00,1'b1,14'h0000,14'h0050,32'h0,32'h0,32'h2222_2222,      2'b10,4'b1010,14'h0050,32'h0,         2'b01,32'h2222_2222,32'h0};
    tbl[5]  = '{2'b11,2'b00,2'b11,2'b00,1'b1,14'h0060,14'h0070,32'h0,32'h0,32'h3333_3333,      2'b01,4'b1011,14'h0060,32'h0,         2'b10,32'h0,32'h3333_3333};
    tbl[6]  = '{2'b10,2'b00,2'b10,2'b00,1'b1,14'h0000,14'h0070,32'h0,32'h0,32'h4444_4444,      2'b10,4'b1010,14'h0070,32'h0,         2'b01,32'h4444_4444,32'h0};
    tbl[7]  = '{2'b01,2'b00,2'b00,2'b00,1'b0,14'h0080,14'h0000,32'h0,32'h0,32'h5555_5555,      2'b01,4'b1000,14'h0080,32'h0,         2'b10,32'h0,32'h5555_5555};
    tbl[8]  = '{2'b10,2'b10,2'b00,2'b10,1'b0,14'h0000,14'h0030,32'h0,32'hCAFE_F00D,32'h6666_6666, 2'b10,4'b1100,14'h0030,32'hCAFE_F00D, 2'b01,32'h6666_6666,32'h0};
    tbl[9]  = '{2'b01,2'b00,2'b01,2'b00,1'b0,14'h0010,14'h0000,32'h0,32'h0,32'h7777_7777,      2'b00,4'b0000,14'h0000,32'h0,         2'b10,32'h0,32'h7777_7777};
    tbl[10] = '{2'b01,2'b00,2'b01,2'b00,1'b0,14'h0010,14'h0000,32'h0,32'h0,32'h1212_1212,      2'b00,4'b0000,14'h0000,32'h0,         2'b00,32'h0,32'h0};
    tbl[11] = '{2'b11,2'b00,2'b11,2'b00,1'b0,14'h0010,14'h0030,32'h0,32'h0,32'h0,              2'b10,4'b1010,14'h0030,32'h0,         2'b00,32'h0,32'h0};
    tbl[12] = '{2'b01,2'b00,2'b01,2'b00,1'b0,14'h0010,14'h0000,32'h0,32'h0,32'h8888_8888,      2'b01,4'b1010,14'h0010,32'h0,         2'b10,32'h0,32'h8888_8888};
    tbl[13] = '{2'b00,2'b00,2'b00,2'b00,1'b0,14'h0000,14'h0000,32'h0,32'h0,32'h9999_9999,      2'b00,4'b0000,14'h0000,32'h0,         2'b01,32'h9999_9999,32'h0};

    // Reset held with both masters requesting, then release.
    idle_inputs();
    RESET = 1'b0;
    @(posedge CLK); #1;
    M0_REQ = 1'b1; M0_RE = 1'b1; M1_REQ = 1'b1; M1_RE = 1'b1;
    @(negedge CLK);
    chk("rst_gnt", 0, {30'h0, M1_GNT, M0_GNT}, 32'h0);
    chk("rst_ioreq", 0, {31'h0, IO_REQ}, 32'h0);
    chk("rst_rvalid", 0, {30'h0, M1_RVALID, M0_RVALID}, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("rel_gnt", 0, {30'h0, M1_GNT, M0_GNT}, 32'h1);
    chk("rel_ioreq", 0, {31'h0, IO_REQ}, 32'h1);
    @(posedge CLK); #1;

    // Directed vector table, one cycle per entry.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i]);
      @(negedge CLK);
      chk("gnt", i, {30'h0, M1_GNT, M0_GNT}, {30'h0, tbl[i].e_gnt});
      chk("io_ctl", i, {28'h0, IO_REQ, IO_WE, IO_RE, IO_DBE}, {28'h0, tbl[i].e_io});
      if (tbl[i].e_gnt != 2'b00) begin
        chk("io_addr", i, {18'h0, IO_ADDR}, {18'h0, tbl[i].e_addr});
        chk("io_wd", i, IO_WD, tbl[i].e_wd);
      end
      chk("rvalid", i, {30'h0, M1_RVALID, M0_RVALID}, {30'h0, tbl[i].e_rv});
      chk("m0_rd", i, M0_RD, tbl[i].e_rd0);
      chk("m1_rd", i, M1_RD, tbl[i].e_rd1);
      @(posedge CLK); #1;
    end

    // Both masters request every cycle for 8 cycles.
    do_reset();
    M0_REQ = 1'b1; M0_RE = 1'b1; M1_REQ = 1'b1; M1_RE = 1'b1;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
`ifdef IO_ARBITER_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      chk("both_gnt", i, {30'h0, M1_GNT, M0_GNT}, {30'h0, exp_g});
      if (M0_GNT) c0++;
      if (M1_GNT) c1++;
      @(posedge CLK); #1;
    end
`ifdef IO_ARBITER_RR_EN
    chk("both_cnt0", 0, c0, 32'd4);
    chk("both_cnt1", 0, c1, 32'd4);
`else
    chk("both_cnt0", 0, c0, 32'd8);
    chk("both_cnt1", 0, c1, 32'd0);
`endif

    // M0 holds LOCK for 20 cycles with M1 waiting: forced release after 16 locked cycles.
    do_reset();
    M0_REQ = 1'b1; M0_RE = 1'b1; M0_LOCK = 1'b1;
    M1_REQ = 1'b1; M1_RE = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 18) begin
        M1_REQ = 1'b0; M1_RE = 1'b0;
      end
      @(negedge CLK);
      exp_g = (c == 17) ? 2'b10 : 2'b01;
      chk("lock_gnt", c, {30'h0, M1_GNT, M0_GNT}, {30'h0, exp_g});
      @(posedge CLK); #1;
    end

    // Reset during the response cycle of an M1 read discards the response.
    do_reset();
    M1_REQ = 1'b1; M1_RE = 1'b1; M1_ADDR = 14'h0123; IO_RD = 32'hFEED_BEEF;
    @(negedge CLK);
    chk("mid_gnt", 0, {30'h0, M1_GNT, M0_GNT}, 32'h2);
    @(posedge CLK); #1;
    M1_REQ = 1'b0; M1_RE = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    chk("mid_rv", 0, {31'h0, M1_RVALID}, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      chk("mid_rv", i, {31'h0, M1_RVALID}, 32'h0);
      chk("mid_rd", i, M1_RD, 32'h0);
      @(posedge CLK); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
